// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux -- receive side of the 4:1 time-multiplexed link.
//
// The sender walks slots 0..3 and drives one channel per beat. A sync marker
// tags the slot-0 beat. This block locks onto the sync marker and stages
// beats 0..2. On the slot-3 beat it publishes all four channels at once,
// together with a one-cycle frame strobe.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    din/sync carry a beat this cycle
//   sync        qualified by in_valid; marks slot 0 of a frame
//   din         beat payload (WIDTH bits)
//   slot        index of the next slot expected (0..3)
//   d0..d3      published channels, held until the next complete frame
//   frame_valid one-cycle pulse: d0..d3 just updated with a complete frame
//   sync_err    one-cycle pulse: framing violation (missing or early sync)
// ---------------------------------------------------------------------------
module tdm_demux #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             sync,
   input  logic [WIDTH-1:0] din,
   output logic [1:0]       slot,
   output logic [WIDTH-1:0] d0,
   output logic [WIDTH-1:0] d1,
   output logic [WIDTH-1:0] d2,
   output logic [WIDTH-1:0] d3,
   output logic             frame_valid,
   output logic             sync_err
);

   typedef enum logic {HUNT, RUN} state_t;

   state_t           r_state;
   logic [1:0]       r_slot;
   logic [WIDTH-1:0] r_s0, r_s1, r_s2;
   logic [WIDTH-1:0] r_d0, r_d1, r_d2, r_d3;
   logic             r_fv, r_err;

   state_t           w_state;
   logic [1:0]       w_slot;
   logic [WIDTH-1:0] w_s0, w_s1, w_s2;
   logic [WIDTH-1:0] w_d0, w_d1, w_d2, w_d3;
   logic             w_fv, w_err;

   // State register: every output is a flop, so the outputs never have a
   // combinational path from the inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= HUNT;
         r_slot  <= 2'd0;
         r_s0    <= '0;
         r_s1    <= '0;
         r_s2    <= '0;
         r_d0    <= '0;
         r_d1    <= '0;
         r_d2    <= '0;
         r_d3    <= '0;
         r_fv    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_slot  <= w_slot;
         r_s0    <= w_s0;
         r_s1    <= w_s1;
         r_s2    <= w_s2;
         r_d0    <= w_d0;
         r_d1    <= w_d1;
         r_d2    <= w_d2;
         r_d3    <= w_d3;
         r_fv    <= w_fv;
         r_err   <= w_err;
      end
   end

   // Next-state logic. Idle cycles hold everything and leave both pulses low.
   always_comb begin
      w_state = r_state;
      w_slot  = r_slot;
      w_s0    = r_s0;
      w_s1    = r_s1;
      w_s2    = r_s2;
      w_d0    = r_d0;
      w_d1    = r_d1;
      w_d2    = r_d2;
      w_d3    = r_d3;
      w_fv    = 1'b0;
      w_err   = 1'b0;

      if (in_valid) begin
         unique case (r_state)
            HUNT: begin
               // Beats without sync are silently dropped while hunting.
               if (sync) begin
                  w_s0    = din;
                  w_slot  = 2'd1;
                  w_state = RUN;
               end
            end
            RUN: begin
               if (sync) begin
                  // A sync beat always starts a new frame. If it arrives
                  // mid-frame, the partial frame is abandoned and the
                  // violation is flagged.
                  w_s0   = din;
                  w_slot = 2'd1;
                  w_err  = (r_slot != 2'd0);
               end else begin
                  unique case (r_slot)
                     2'd0: begin
                        w_err   = 1'b1;
                        w_state = HUNT;
                     end
                     2'd1: begin
                        w_s1   = din;
                        w_slot = 2'd2;
                     end
                     2'd2: begin
                        w_s2   = din;
                        w_slot = 2'd3;
                     end
                     default: begin
                        // Slot 3 publishes directly from din. No s3 register
                        // is needed.
                        w_d0   = r_s0;
                        w_d1   = r_s1;
                        w_d2   = r_s2;
                        w_d3   = din;
                        w_fv   = 1'b1;
                        w_slot = 2'd0;
                     end
                  endcase
               end
            end
            default: begin
               w_state = HUNT;
               w_slot  = 2'd0;
            end
         endcase
      end
   end

   assign slot        = r_slot;
   assign d0          = r_d0;
   assign d1          = r_d1;
   assign d2          = r_d2;
   assign d3          = r_d3;
   assign frame_valid = r_fv;
   assign sync_err    = r_err;

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         sync;
   logic [W-1:0] din;
   logic [1:0]   slot;
   logic [W-1:0] d0, d1, d2, d3;
   logic         frame_valid;
   logic         sync_err;

   int total = 0;
   int bad   = 0;
   int fv_seen = 0;
   int err_seen = 0;

   tdm_demux #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .sync(sync), .din(din),
      .slot(slot), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .frame_valid(frame_valid), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   // Reference model: a frame is the list of beats collected since the last
   // sync. Its length is the next expected slot.
   bit           m_locked;
   logic [W-1:0] m_cur[$];
   logic [W-1:0] m_d[4];
   bit           m_fv, m_err;

   task automatic model(input logic r, input logic v, input logic s,
                        input logic [W-1:0] d);
      m_fv  = 0;
      m_err = 0;
      if (r) begin
         m_locked = 0;
         m_cur.delete();
         for (int i = 0; i < 4; i++) m_d[i] = '0;
      end else if (v) begin
         if (!m_locked) begin
            if (s) begin
               m_cur.delete();
               m_cur.push_back(d);
               m_locked = 1;
            end
         end else if (s) begin
            if (m_cur.size() != 0) m_err = 1;
            m_cur.delete();
            m_cur.push_back(d);
         end else if (m_cur.size() == 0) begin
            m_err    = 1;
            m_locked = 0;
         end else begin
            m_cur.push_back(d);
            if (m_cur.size() == 4) begin
               for (int i = 0; i < 4; i++) m_d[i] = m_cur[i];
               m_fv = 1;
               m_cur.delete();
            end
         end
      end
   endtask

   function automatic logic [19:0] actual();
      return {slot, d0, d1, d2, d3, frame_valid, sync_err};
   endfunction

   function automatic logic [19:0] expected_model();
      logic [1:0] sl;
      sl = 2'(m_cur.size());
      return {sl, m_d[0], m_d[1], m_d[2], m_d[3], m_fv, m_err};
   endfunction

   task automatic cmp(input string name, input logic [19:0] act,
                      input logic [19:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got slot=%0d d=%h fv=%b err=%b, want slot=%0d d=%h fv=%b err=%b",
                  name, act[19:18], act[17:2], act[1], act[0],
                  exp[19:18], exp[17:2], exp[1], exp[0]);
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Drive one cycle, advance the model and sample 1 time unit after the edge.
   task automatic drive(input logic r, input logic v, input logic s,
                        input logic [W-1:0] d);
      rst = r; in_valid = v; sync = s; din = d;
      @(posedge clk);
      #1;
      model(r, v, s, d);
      if (frame_valid) fv_seen++;
      if (sync_err) err_seen++;
   endtask

   task automatic step(input string name, input logic r, input logic v,
                       input logic s, input logic [W-1:0] d);
      drive(r, v, s, d);
      cmp(name, actual(), expected_model());
   endtask

   typedef struct {
      logic         r, v, s;
      logic [W-1:0] din;
      logic [1:0]   slot;
      logic [15:0]  dpk;
      logic         fv, err;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic v, input logic s,
                               input logic [W-1:0] d, input logic [1:0] sl,
                               input logic [15:0] dp, input logic fv,
                               input logic err);
      vec_t x;
      x.r = r; x.v = v; x.s = s; x.din = d; x.slot = sl; x.dpk = dp;
      x.fv = fv; x.err = err;
      return x;
   endfunction

   vec_t tbl[14];

   initial begin
      // Reset, one frame 1,0,1,0, then back-to-back frames 1,0,1,0 / 0,1,0,1.
      tbl[0]  = mk(1, 0, 0, 0, 0, 16'h0000, 0, 0);
      tbl[1]  = mk(0, 1, 1, 1, 1, 16'h0000, 0, 0);
      tbl[2]  = mk(0, 1, 0, 0, 2, 16'h0000, 0, 0);
      tbl[3]  = mk(0, 1, 0, 1, 3, 16'h0000, 0, 0);
      tbl[4]  = mk(0, 1, 0, 0, 0, 16'h1010, 1, 0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 16'h1010, 0, 0);
      tbl[6]  = mk(0, 1, 1, 1, 1, 16'h1010, 0, 0);
      tbl[7]  = mk(0, 1, 0, 0, 2, 16'h1010, 0, 0);
      tbl[8]  = mk(0, 1, 0, 1, 3, 16'h1010, 0, 0);
      tbl[9]  = mk(0, 1, 0, 0, 0, 16'h1010, 1, 0);
      tbl[10] = mk(0, 1, 1, 0, 1, 16'h1010, 0, 0);
      tbl[11] = mk(0, 1, 0, 1, 2, 16'h1010, 0, 0);
      tbl[12] = mk(0, 1, 0, 0, 3, 16'h1010, 0, 0);
      tbl[13] = mk(0, 1, 0, 1, 0, 16'h0101, 1, 0);

      rst = 1; in_valid = 0; sync = 0; din = '0;
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].din);
         cmp($sformatf("vec%0d", i), actual(),
             {tbl[i].slot, tbl[i].dpk, tbl[i].fv, tbl[i].err});
      end

      // Gapped frame 1,1,0,1 with three idle cycles between beats.
      fv_seen = 0;
      step("gap_b0", 0, 1, 1, 4'd1);
      for (int k = 0; k < 3; k++) begin
         for (int g = 0; g < 3; g++) step("gap_idle", 0, 0, 0, 4'($urandom));
         step("gap_beat", 0, 1, 0, (k == 1) ? 4'd0 : 4'd1);
      end
      chk("gap_fv_count", fv_seen, 1);
      cmp("gap_result", actual(), {2'd0, 16'h1101, 1'b1, 1'b0});

      // Early sync on the slot-2 beat of the frame after a good one.
      step("es_a0", 0, 1, 1, 4'd5);
      step("es_a1", 0, 1, 0, 4'd6);
      step("es_a2", 0, 1, 0, 4'd7);
      step("es_a3", 0, 1, 0, 4'd8);
      step("es_b0", 0, 1, 1, 4'd9);
      step("es_b1", 0, 1, 0, 4'd10);
      step("es_b2", 0, 1, 1, 4'd11);
      cmp("early_sync", actual(), {2'd1, 16'h5678, 1'b0, 1'b1});
      step("es_c1", 0, 1, 0, 4'd12);
      step("es_c2", 0, 1, 0, 4'd13);
      step("es_c3", 0, 1, 0, 4'd14);
      cmp("after_early", actual(), {2'd0, 16'hBCDE, 1'b1, 1'b0});

      // Missing sync at slot 0: error, back to HUNT, sync=0 beats ignored.
      step("ms_bad", 0, 1, 0, 4'd3);
      cmp("missing_sync", actual(), {2'd0, 16'hBCDE, 1'b0, 1'b1});
      err_seen = 0;
      step("ms_h0", 0, 1, 0, 4'd4);
      step("ms_h1", 0, 1, 0, 4'd5);
      step("ms_h2", 0, 1, 0, 4'd6);
      chk("hunt_no_err", err_seen, 0);
      step("ms_r0", 0, 1, 1, 4'd2);
      step("ms_r1", 0, 1, 0, 4'd4);
      step("ms_r2", 0, 1, 0, 4'd6);
      step("ms_r3", 0, 1, 0, 4'd8);
      cmp("resync", actual(), {2'd0, 16'h2468, 1'b1, 1'b0});

      // Reset after beat 2 discards the frame; remaining beats do nothing.
      step("rs_b0", 0, 1, 1, 4'd7);
      step("rs_b1", 0, 1, 0, 4'd7);
      step("rs_rst", 1, 0, 0, 4'd0);
      cmp("mid_reset", actual(), 20'd0);
      fv_seen = 0;
      step("rs_b2", 0, 1, 0, 4'd7);
      step("rs_b3", 0, 1, 0, 4'd7);
      chk("reset_no_fv", fv_seen, 0);

      // Randomised traffic against the model; mostly well-formed framing.
      for (int n = 0; n < 800; n++) begin
         logic r, v, s;
         logic [W-1:0] d;
         r = ($urandom_range(0, 149) == 0);
         v = ($urandom_range(0, 9) < 7);
         s = (m_cur.size() == 0) ^ ($urandom_range(0, 9) == 0);
         d = W'($urandom);
         step("rand", r, v, s, d);
         if (frame_valid && sync_err) chk("fv_err_exclusive", 1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side end of the team's 4:1 multiplexed link. A sender walks select 0→3 and drives one channel per beat. This block rebuilds the four channel values.
- Beats are tagged with a slot-0 sync marker.
- The block counts slots, stages each beat into its channel register, and publishes all four channels together with a one-cycle frame strobe.
- It sits directly behind a MUX-driven serial/TDM lane and feeds parallel consumers.

Parameters:
- WIDTH, 1, bit width of each channel and of din.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  din/sync carry a beat this cycle.
- sync  input  1  qualified by in_valid; high marks slot 0 (d0) of a frame.
- din  input  WIDTH  beat payload.
- slot  output  2  index of the next slot expected (0..3).
- d0  output  WIDTH  published channel 0.
- d1  output  WIDTH  published channel 1.
- d2  output  WIDTH  published channel 2.
- d3  output  WIDTH  published channel 3.
- frame_valid  output  1  one-cycle pulse: d0..d3 were just updated with a complete frame.
- sync_err  output  1  one-cycle pulse: framing violation detected.

Behaviour:
- Reset (rst high at a clk edge) sets:
  - state=HUNT, slot=0;
  - staging registers s0..s2=0;
  - d0..d3=0, frame_valid=0, sync_err=0.
- Reset mid-frame discards the partial frame. d0..d3 return to 0.
- The state machine has two states: HUNT and RUN. A beat is one cycle with in_valid=1. Cycles with in_valid=0 change no state, slot, staging or d-outputs. frame_valid and sync_err are always 0 on such cycles.
- HUNT:
  - beat with sync=1 → s0<=din, slot<=1, state<=RUN;
  - beat with sync=0 → dropped, stays in HUNT, no error. sync_err asserts only in RUN.
- RUN, slot=1 or 2, sync=0 → s[slot]<=din, slot<=slot+1.
- RUN, slot=3, sync=0 → final beat of the frame. At that edge:
  - d0<=s0, d1<=s1, d2<=s2, d3<=din;
  - frame_valid<=1 for exactly one cycle;
  - slot wraps to 0; state stays RUN.
- RUN, slot=0, sync=1 → start of the next frame: s0<=din, slot<=1. Back-to-back frames need no idle cycle.
- RUN, slot=0, sync=0 → missing sync:
  - sync_err<=1 for one cycle;
  - beat dropped;
  - state<=HUNT, slot stays 0.
- RUN, slot=1..3, sync=1 → early sync:
  - sync_err<=1 for one cycle;
  - partial frame discarded;
  - beat taken as the new slot 0: s0<=din, slot<=1, state stays RUN;
  - d0..d3 unchanged, no frame_valid.
- Latency: d0..d3 and frame_valid become visible in the cycle after the clk edge that sampled the slot-3 beat. Each d-output holds its value until the next completed frame or reset.
- frame_valid and sync_err are never high in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- slot arithmetic is 2-bit modulo 4. The wrap 3→0 is the only legal wrap.

Test Plan:
1. Reset, then WIDTH=1 beats (sync,din) = (1,1),(0,0),(0,1),(0,0) → one cycle after the 4th beat:
   - d0=1, d1=0, d2=1, d3=0;
   - frame_valid=1 for exactly 1 cycle;
   - slot=0, sync_err never set.
2. Two back-to-back frames 1,0,1,0 then 0,1,0,1, with no gaps → two frame_valid pulses 4 cycles apart. Final d0..d3 = 0,1,0,1.
3. Frame 1,1,0,1 with in_valid=0 for 3 cycles inserted between each beat → the same result as gap-free. frame_valid occurs once, after the last beat. Outputs are stable during the gaps.
4. Valid frame, then sync=1 on the slot-2 beat of the next frame →
   - sync_err pulses 1 cycle;
   - d0..d3 keep the first frame's values;
   - slot=1 after the error beat;
   - 3 more beats complete a frame and produce frame_valid.
5. After a frame, a beat with sync=0 at slot 0 → sync_err pulses and the block returns to HUNT. Further sync=0 beats are ignored with no sync_err. The next sync=1 beat resynchronises.
6. Assert rst after beat 2 of a frame → next cycle d0..d3=0, slot=0, HUNT. Beats 3 and 4 (sync=0) produce no frame_valid.
